mem_arbiter: RTL
================

# mem_arbiter

Sequences the single-port instruction/data memory (1 MiB at 0x8002_0000) between two requesters: the fetch port (read-only, word or burst line fills) and the data port (single-word load/store). Arbitrates round-robin, range- and alignment-checks each request, and issues per-beat memory accesses with explicit addresses. Sits between the pipeline's IF/MEM stages and `memory`.

## Interface
- `DATA_WIDTH`, 32, word width
- `ADDR_WIDTH`, 32, byte address width
- `START_ADDR`, 32'h8002_0000, lowest legal byte address
- `DEPTH`, 1048576, memory size in bytes
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `if_req`/`if_addr`/`if_size`  in  1/32/2  fetch request, byte address, burst code
- `if_gnt`/`if_rvalid`/`if_rdata`/`if_done`/`if_err`  out  1/1/32/1/1  fetch response
- `d_req`/`d_we`/`d_addr`/`d_wdata`  in  1/1/32/32  data request (we=1 store)
- `d_gnt`/`d_rvalid`/`d_rdata`/`d_done`/`d_err`  out  1/1/32/1/1  data response
- `mem_address`/`mem_data_in`  out  32/32  beat address, write data
- `mem_access_size`  out  2  burst code of current transaction
- `mem_rw`  out  1  1=read, 0=write
- `mem_enable`  out  1  beat valid
- `mem_busy`  in  1  memory stall; beat not accepted
- `mem_data_out`  in  32  read data, valid the cycle after acceptance

## Operation
- Burst code: 00=1, 01=4, 10=8, 11=16 beats; data port always 00.
- States: IDLE, BURST, ERR.
- IDLE: sample requests at edge; none -> stay. One -> serve it. Both -> round-robin: serve port not served last; after reset data port wins first tie.
- Check on grant: addr[1:0]!=0, addr<START_ADDR, or addr+4*beats>START_ADDR+DEPTH -> ERR; else latch addr/size/we/wdata/owner, beat counter = beats-1, -> BURST.
- BURST: mem_enable=1; beat accepted at edge with mem_busy=0 -> mem_address += 4, counter -1; last beat accepted -> IDLE. mem_busy=1 holds address/enable/data unchanged.
- ERR: owner's gnt, err, done high one cycle; no memory access; -> IDLE.
- Read return: rvalid registered flag set by each accepted read beat, tagged with owner; rdata = mem_data_out pass-through; done asserts with last rvalid. Write: done one cycle after beat accepted, no rvalid.
- Requester holds req and payload until gnt; gnt pulses one cycle, in first BURST cycle or ERR cycle. Non-owner outputs stay 0.
- Address wrap past 0xFFFF_FFFF impossible after range check; compute end address in 33 bits.

## Timing
- Reset (async, immediate): state IDLE, all gnt/rvalid/done/err 0, rdata 0, mem_enable 0, mem_rw 1, mem_address 0, mem_data_in 0, mem_access_size 0, rr pointer to favour data. In-flight rvalid dropped.
- req visible at edge N -> gnt and mem_enable high cycle N..N+1 -> unstalled read data (rvalid) cycle N+1..N+2.
- 4-beat fill, no stalls: mem_enable 4 cycles, rvalid 4 consecutive cycles, done on 4th.
- One IDLE bubble between transactions; rvalid of last beat overlaps next transaction's IDLE cycle.
- req dropped before gnt: request cancelled, no effect.

## Structure
- Package `mem_pkg`: burst-code encoding and beats function, START_ADDR/DEPTH constants, state enum.
- Sub-module `rr_arbiter2`: 2-way round-robin with last-served register, updated on grant.

## Test plan
- Store 0xDEADBEEF to 0x8002_0010, then load -> d_done after store; load d_rdata=0xDEADBEEF, d_rvalid one cycle.
- Fetch burst 01 at 0x8002_0000 over preloaded words 0..3 -> mem_address 0x..00/04/08/0C, if_rvalid 4 cycles, if_done on 4th.
- Both req same edge, repeated 4 times -> grants alternate d,i,d,i.
- mem_busy high 3 cycles mid-burst -> address held, no rvalid gaps beyond stall, data order preserved.
- d_addr 0x8002_0002, if_addr 0x8011_FFF8 size 01, d_addr 0x0 -> err+done+gnt one cycle each, mem_enable never high.
- reset asserted mid-burst (beat 2 of 8) -> mem_enable and if_rvalid low same cycle; fresh fetch after release succeeds.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg
// Shared definitions for the instruction/data memory arbiter: memory window
// constants, burst-code encoding, the beats-per-burst helper and the FSM
// state encoding. No ports.
package mem_pkg;

    localparam logic [31:0] MEM_START_ADDR = 32'h8002_0000;
    localparam int unsigned MEM_DEPTH      = 1048576;

    typedef enum logic [1:0] {
        BURST_1  = 2'b00,
        BURST_4  = 2'b01,
        BURST_8  = 2'b10,
        BURST_16 = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_ERR   = 2'd2
    } state_e;

    function automatic logic [4:0] burst_beats(input logic [1:0] code);
        case (code)
            BURST_1:  return 5'd1;
            BURST_4:  return 5'd4;
            BURST_8:  return 5'd8;
            default:  return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter2
// Two-way round-robin arbiter. Bit 0 = data port, bit 1 = fetch port.
// A lone requester always wins; on a tie the port not served last wins.
// The last-served register comes out of reset pointing at fetch so the
// data port wins the first tie.
// Ports:
//   clock, reset  : clock, asynchronous active-high reset
//   req[1:0]      : request vector
//   update        : grant is being taken this cycle; record the winner
//   gnt[1:0]      : one-hot grant (combinational)
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);

    logic last_fetch_q;

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_fetch_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_fetch_q <= 1'b1;
        end else if (update && (gnt != 2'b00)) begin
            last_fetch_q <= gnt[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single-port instruction/data memory between the fetch port
// (read-only, 1/4/8/16-beat bursts) and the data port (single-word load or
// store). Requests are range- and alignment-checked on grant, then issued as
// per-beat memory accesses with explicit addresses.
// Ports:
//   clock, reset                         : clock, async active-high reset
//   if_req/if_addr/if_size               : fetch request
//   if_gnt/if_rvalid/if_rdata/if_done/if_err : fetch response
//   d_req/d_we/d_addr/d_wdata            : data request (we=1 store)
//   d_gnt/d_rvalid/d_rdata/d_done/d_err  : data response
//   mem_address/mem_data_in/mem_access_size/mem_rw/mem_enable : beat issue
//   mem_busy                             : memory stall, beat not accepted
//   mem_data_out                         : read data, cycle after acceptance
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | sample requests, arbitrate, check, latch transaction
// ST_BURST | present beats; advance on each beat accepted (mem_busy=0)
// ST_ERR   | one-cycle gnt+err+done to the owner, no memory access
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(MEM_START_ADDR),
    parameter int unsigned DEPTH = MEM_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic [1:0]            if_size,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_done,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,
    output logic                  d_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [1:0]            mem_access_size,
    output logic                  mem_rw,
    output logic                  mem_enable,
    input  logic                  mem_busy,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    state_e state_q, state_d;

    logic       owner_fetch_q;
    logic       gnt_first_q;
    logic [3:0] beat_cnt_q;
    logic       rvalid_q;
    logic       done_q;
    logic       resp_fetch_q;

    logic [1:0]            req_vec, arb_gnt;
    logic                  arb_update;
    logic                  sel_fetch;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [1:0]            sel_size;
    logic [4:0]            sel_beats;
    logic [ADDR_WIDTH:0]   sel_end, mem_limit;
    logic                  sel_bad;
    logic                  take_req;
    logic                  accept;
    logic                  last_beat;

    assign req_vec    = {if_req, d_req};
    assign arb_update = (state_q == ST_IDLE);
    assign take_req   = (state_q == ST_IDLE) && (req_vec != 2'b00);

    rr_arbiter2 u_rr (
        .clock  (clock),
        .reset  (reset),
        .req    (req_vec),
        .update (arb_update),
        .gnt    (arb_gnt)
    );

    assign sel_fetch = arb_gnt[1];
    assign sel_addr  = sel_fetch ? if_addr : d_addr;
    assign sel_size  = sel_fetch ? if_size : BURST_1;
    assign sel_beats = burst_beats(sel_size);

    // End address and limit carry one extra bit so a request near the top of
    // the address space cannot wrap past the limit check.
    assign sel_end   = {1'b0, sel_addr} + (ADDR_WIDTH+1)'({sel_beats, 2'b00});
    assign mem_limit = (ADDR_WIDTH+1)'(START_ADDR) + (ADDR_WIDTH+1)'(DEPTH);
    assign sel_bad   = (sel_addr[1:0] != 2'b00) || (sel_addr < START_ADDR) ||
                       (sel_end > mem_limit);

    assign accept    = (state_q == ST_BURST) && !mem_busy;
    assign last_beat = (beat_cnt_q == 4'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_enable = 1'b0;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        if_err     = 1'b0;
        d_err      = 1'b0;
        if_done    = 1'b0;
        d_done     = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        if_rdata   = '0;
        d_rdata    = '0;

        case (state_q)
            ST_IDLE: begin
                if (take_req) begin
                    state_d = sel_bad ? ST_ERR : ST_BURST;
                end
            end
            ST_BURST: begin
                mem_enable = 1'b1;
                if (accept && last_beat) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
                if (owner_fetch_q) begin
                    if_err  = 1'b1;
                    if_done = 1'b1;
                end else begin
                    d_err   = 1'b1;
                    d_done  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (gnt_first_q) begin
            if (owner_fetch_q) if_gnt = 1'b1;
            else               d_gnt  = 1'b1;
        end

        // Response flags carry their own owner tag: the last beat's response
        // lands in the IDLE bubble, after owner_fetch_q may be reused.
        if (rvalid_q) begin
            if (resp_fetch_q) begin
                if_rvalid = 1'b1;
                if_rdata  = mem_data_out;
            end else begin
                d_rvalid  = 1'b1;
                d_rdata   = mem_data_out;
            end
        end
        if (done_q) begin
            if (resp_fetch_q) if_done = 1'b1;
            else              d_done  = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_fetch_q   <= 1'b0;
            gnt_first_q     <= 1'b0;
            beat_cnt_q      <= 4'd0;
            rvalid_q        <= 1'b0;
            done_q          <= 1'b0;
            resp_fetch_q    <= 1'b0;
            mem_address     <= '0;
            mem_data_in     <= '0;
            mem_access_size <= 2'b00;
            mem_rw          <= 1'b1;
        end else begin
            gnt_first_q <= 1'b0;
            rvalid_q    <= 1'b0;
            done_q      <= 1'b0;

            if (take_req) begin
                owner_fetch_q <= sel_fetch;
                gnt_first_q   <= 1'b1;
                if (!sel_bad) begin
                    mem_address     <= sel_addr;
                    mem_access_size <= sel_size;
                    mem_rw          <= sel_fetch | ~d_we;
                    beat_cnt_q      <= 4'(sel_beats - 5'd1);
                    if (!sel_fetch) begin
                        mem_data_in <= d_wdata;
                    end
                end
            end

            if (accept) begin
                mem_address  <= mem_address + ADDR_WIDTH'(4);
                beat_cnt_q   <= beat_cnt_q - 4'd1;
                rvalid_q     <= mem_rw;
                done_q       <= last_beat;
                resp_fetch_q <= owner_fetch_q;
            end
        end
    end

endmodule
